store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//  MEM-stage store write buffer: the write-side counterpart of the load/writeback path.
//  Accepts stores (byte/half/word) from the EX/MEM latch, builds aligned write data and
//  byte enables, and queues entries in a DEPTH-deep FIFO.
//  A drain FSM retires entries to data memory over a req/ack handshake.
//  Flags pending same-word stores so the hazard unit can stall a dependent load.
// PARAMETERS
//  DEPTH  4  FIFO entries; power of two, >=2
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   asynchronous, active-low reset
//  st_valid     in   1   store request valid
//  st_ready     out  1   buffer can accept a store (= !full)
//  st_addr      in   32  byte address of store
//  st_data      in   32  store data, right-justified
//  st_byte      in   1   byte store (sb)
//  st_half      in   1   halfword store (sh); neither set = word (sw)
//  misalign     out  1   registered one-cycle pulse: misaligned store was dropped
//  ld_check     in   1   a load in MEM wants a hazard check
//  ld_addr      in   32  load byte address
//  ld_hazard    out  1   combinational: pending store hits same word as ld_addr
//  dm_req       out  1   memory write request
//  dm_addr      out  32  word-aligned address ({addr[31:2],2'b00})
//  dm_wdata     out  32  replicated write data
//  dm_be        out  4   byte enables, bit i = byte lane i
//  dm_ack       in   1   memory accepted current write
//  empty        out  1   no pending entries
// BEHAVIOUR
//  Reset (rst=0, async): FIFO cleared, count=0, state=IDLE, dm_req=0, misalign=0, empty=1;
//   pending writes are discarded, including one mid-handshake.
//  Formatting at enqueue, stored per entry:
//   byte: be=4'b0001<<addr[1:0], wdata={4{data[7:0]}}
//   half: be= addr[1] ? 4'b1100 : 4'b0011, wdata={2{data[15:0]}}
//   word: be=4'b1111, wdata=data
//  Alignment: half with addr[0]=1, or word with addr[1:0]!=0 is misaligned.
//   Misaligned store is consumed (handshake completes) but not enqueued.
//   misalign=1 for exactly the following cycle.
//  Enqueue: st_valid & st_ready & aligned. Write-pointer wraps modulo DEPTH.
//  st_ready = !full. It does not look ahead to a same-cycle pop.
//  When full, st_ready=0 even while dm_ack pops the head.
//  Drain FSM (dm_req = state==ISSUE; dm_addr/dm_wdata/dm_be come from the FIFO head):
//   IDLE : count!=0 -> ISSUE next cycle.
//          An entry enqueued at cycle t gives dm_req=1 at t+2.
//   ISSUE: dm_* stay stable until dm_ack.
//          dm_ack: pop head. Stay ISSUE if count>1 after this pop, else -> IDLE.
//          Back-to-back: next entry is presented the cycle after ack.
//  Simultaneous push+pop: count unchanged, both pointers advance.
//   An empty-FIFO push during a final-ack pop leaves count=1;
//   the FSM goes IDLE -> ISSUE one cycle later.
//  dm_ack outside ISSUE is ignored.
//  ld_hazard = ld_check & OR over valid entries of (entry.addr[31:2]==ld_addr[31:2]).
//   Covers the head entry, including during its ack cycle.
//   Does not cover a store being enqueued in the same cycle.
//  empty = (count==0).
// TESTING
//  sb addr 0x1003 data 0x000000AB -> dm_addr 0x1000, dm_be 4'b1000, dm_wdata 0xABABABAB,
//   dm_req at t+2.
//  sh addr 0x2002 data 0x00001234 -> dm_be 4'b1100, dm_wdata 0x12341234.
//   sw 0x2004 data 0xDEADBEEF -> be 1111.
//  sw addr 0x3001 -> misalign=1 for one cycle, nothing enqueued, dm_req stays 0.
//   sh 0x3001 -> same response.
//  4 stores with dm_ack=0 -> st_ready=0 after 4th. One ack -> st_ready=1 next cycle.
//   Then hold dm_ack=1: 4 writes retire in consecutive cycles, FIFO order.
//  Pending sw 0x1000; ld_check=1, ld_addr 0x1002 -> ld_hazard=1.
//   ld_addr 0x1004 -> 0. After retire -> 0.
//  rst low while in ISSUE with 3 entries -> dm_req=0, empty=1 immediately.
//   No writes after rst releases.

Source files
------------

// File: rtl/store_buffer.sv
// MEM-stage store write buffer: formats sb/sh/sw into aligned data and byte enables,
// queues them in a DEPTH-entry FIFO and drains them to data memory over req/ack.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic        st_byte,
  input  logic        st_half,
  output logic        misalign,
  input  logic        ld_check,
  input  logic [31:0] ld_addr,
  output logic        ld_hazard,
  output logic        dm_req,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic        dm_ack,
  output logic        empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } entry_t;

  typedef enum logic [0:0] {IDLE, ISSUE} state_e;

  state_e             state_q, state_d;
  entry_t             fifo_q [DEPTH];
  entry_t             new_entry;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               misalign_q, misalign_d;
  logic               mis_c, push, pop, full;
  logic               unused_ld_low;

  assign unused_ld_low = &{1'b0, ld_addr[1:0]};

  // Store formatting and alignment check; byte takes priority if both size bits are set.
  always_comb begin
    new_entry       = '0;
    new_entry.waddr = st_addr[31:2];
    mis_c           = 1'b0;
    if (st_byte) begin
      new_entry.be    = 4'b0001 << st_addr[1:0];
      new_entry.wdata = {4{st_data[7:0]}};
    end else if (st_half) begin
      new_entry.be    = st_addr[1] ? 4'b1100 : 4'b0011;
      new_entry.wdata = {2{st_data[15:0]}};
      mis_c           = st_addr[0];
    end else begin
      new_entry.be    = 4'b1111;
      new_entry.wdata = st_data;
      mis_c           = |st_addr[1:0];
    end
  end

  assign full       = (count_q == CNT_W'(DEPTH));
  assign st_ready   = !full;
  assign empty      = (count_q == '0);
  assign push       = st_valid & st_ready & !mis_c;
  assign pop        = (state_q == ISSUE) & dm_ack;
  assign misalign_d = st_valid & st_ready & mis_c;
  assign count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
  assign misalign   = misalign_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= new_entry;
  end

  // Word-granular hazard against every occupied slot, head included.
  always_comb begin
    logic [PTR_W-1:0] offs;
    ld_hazard = 1'b0;
    offs      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PTR_W'(i) - rd_ptr_q;
      if ((CNT_W'(offs) < count_q) && (fifo_q[i].waddr == ld_addr[31:2]))
        ld_hazard = ld_check;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Stay in ISSUE across an ack only if entries remain behind the one being popped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (count_q != '0) state_d = ISSUE;
      ISSUE:   if (dm_ack) state_d = (count_q > CNT_W'(1)) ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dm_req   = (state_q == ISSUE);
    dm_addr  = {fifo_q[rd_ptr_q].waddr, 2'b00};
    dm_wdata = fifo_q[rd_ptr_q].wdata;
    dm_be    = fifo_q[rd_ptr_q].be;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: formatting, misalignment, full/drain, hazard and reset.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid, st_ready, st_byte, st_half;
  logic [31:0] st_addr, st_data;
  logic        misalign, ld_check, ld_hazard;
  logic [31:0] ld_addr;
  logic        dm_req, dm_ack, empty;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;

  int checks = 0;
  int errors = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .st_byte(st_byte), .st_half(st_half), .misalign(misalign),
    .ld_check(ld_check), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_ack(dm_ack), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic b, input logic h);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_byte  = b;
    st_half  = h;
  endtask

  initial begin
    rst = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_byte = 1'b0; st_half = 1'b0;
    ld_check = 1'b0; ld_addr = '0; dm_ack = 1'b0;
    #1;
    chk("rst_dm_req", 32'(dm_req), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ready", 32'(st_ready), 32'd1);
    chk("rst_misalign", 32'(misalign), 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // sb 0x1003
    drive(32'h1003, 32'h0000_00AB, 1'b1, 1'b0);
    tick();
    st_valid = 1'b0;
    chk("sb_t1_req", 32'(dm_req), 32'd0);
    chk("sb_t1_empty", 32'(empty), 32'd0);
    tick();
    chk("sb_t2_req", 32'(dm_req), 32'd1);
    chk("sb_addr", dm_addr, 32'h0000_1000);
    chk("sb_be", 32'(dm_be), 32'h8);
    chk("sb_wdata", dm_wdata, 32'hABAB_ABAB);
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    chk("sb_done_req", 32'(dm_req), 32'd0);
    chk("sb_done_empty", 32'(empty), 32'd1);

    // sh 0x2002 then sw 0x2004, drained back to back
    drive(32'h2002, 32'h0000_1234, 1'b0, 1'b1);
    tick();
    drive(32'h2004, 32'hDEAD_BEEF, 1'b0, 1'b0);
    tick();
    st_valid = 1'b0;
    chk("sh_req", 32'(dm_req), 32'd1);
    chk("sh_addr", dm_addr, 32'h0000_2000);
    chk("sh_be", 32'(dm_be), 32'hC);
    chk("sh_wdata", dm_wdata, 32'h1234_1234);
    dm_ack = 1'b1;
    tick();
    chk("sw_req", 32'(dm_req), 32'd1);
    chk("sw_addr", dm_addr, 32'h0000_2004);
    chk("sw_be", 32'(dm_be), 32'hF);
    chk("sw_wdata", dm_wdata, 32'hDEAD_BEEF);
    tick();
    dm_ack = 1'b0;
    chk("sw_done_req", 32'(dm_req), 32'd0);
    chk("sw_done_empty", 32'(empty), 32'd1);

    // misaligned sw 0x3001 and sh 0x3001
    drive(32'h3001, 32'h1111_1111, 1'b0, 1'b0);
    tick();
    st_valid = 1'b0;
    chk("mis_sw_pulse", 32'(misalign), 32'd1);
    chk("mis_sw_empty", 32'(empty), 32'd1);
    tick();
    chk("mis_sw_clear", 32'(misalign), 32'd0);
    chk("mis_sw_req", 32'(dm_req), 32'd0);
    drive(32'h3001, 32'h2222_2222, 1'b0, 1'b1);
    tick();
    st_valid = 1'b0;
    chk("mis_sh_pulse", 32'(misalign), 32'd1);
    chk("mis_sh_empty", 32'(empty), 32'd1);
    tick();
    chk("mis_sh_clear", 32'(misalign), 32'd0);
    chk("mis_sh_req", 32'(dm_req), 32'd0);
    chk("mis_sh_empty2", 32'(empty), 32'd1);

    // Fill to full, single ack, then streaming acks
    drive(32'h4000, 32'hA0, 1'b0, 1'b0); tick();
    drive(32'h4004, 32'hA1, 1'b0, 1'b0); tick();
    drive(32'h4008, 32'hA2, 1'b0, 1'b0); tick();
    drive(32'h400C, 32'hA3, 1'b0, 1'b0); tick();
    st_valid = 1'b0;
    chk("full_ready", 32'(st_ready), 32'd0);
    chk("full_req", 32'(dm_req), 32'd1);
    chk("full_head", dm_addr, 32'h0000_4000);
    chk("full_wdata", dm_wdata, 32'h0000_00A0);
    dm_ack = 1'b1;
    #1;
    chk("full_ready_ack", 32'(st_ready), 32'd0);
    tick();
    chk("after_ack_ready", 32'(st_ready), 32'd1);
    chk("stream0_req", 32'(dm_req), 32'd1);
    chk("stream0_addr", dm_addr, 32'h0000_4004);
    drive(32'h4010, 32'hA4, 1'b0, 1'b0);
    tick();
    st_valid = 1'b0;
    chk("stream1_req", 32'(dm_req), 32'd1);
    chk("stream1_addr", dm_addr, 32'h0000_4008);
    tick();
    chk("stream2_req", 32'(dm_req), 32'd1);
    chk("stream2_addr", dm_addr, 32'h0000_400C);
    tick();
    chk("stream3_req", 32'(dm_req), 32'd1);
    chk("stream3_addr", dm_addr, 32'h0000_4010);
    chk("stream3_wdata", dm_wdata, 32'h0000_00A4);
    tick();
    dm_ack = 1'b0;
    chk("stream_done_req", 32'(dm_req), 32'd0);
    chk("stream_done_empty", 32'(empty), 32'd1);

    // Load hazard against a pending sw 0x1000
    drive(32'h1000, 32'h5555_5555, 1'b0, 1'b0);
    ld_check = 1'b1;
    ld_addr  = 32'h1002;
    #1;
    chk("hz_same_cycle", 32'(ld_hazard), 32'd0);
    tick();
    st_valid = 1'b0;
    #1;
    chk("hz_hit", 32'(ld_hazard), 32'd1);
    ld_addr = 32'h1004;
    #1;
    chk("hz_other_word", 32'(ld_hazard), 32'd0);
    ld_addr  = 32'h1000;
    ld_check = 1'b0;
    #1;
    chk("hz_no_check", 32'(ld_hazard), 32'd0);
    ld_check = 1'b1;
    tick();
    dm_ack = 1'b1;
    #1;
    chk("hz_ack_cycle", 32'(ld_hazard), 32'd1);
    tick();
    dm_ack = 1'b0;
    #1;
    chk("hz_retired", 32'(ld_hazard), 32'd0);
    ld_check = 1'b0;

    // Reset while issuing with three entries queued
    drive(32'h5000, 32'hB0, 1'b0, 1'b0); tick();
    drive(32'h5004, 32'hB1, 1'b0, 1'b0); tick();
    drive(32'h5008, 32'hB2, 1'b0, 1'b0); tick();
    st_valid = 1'b0;
    chk("pre_rst_req", 32'(dm_req), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_req", 32'(dm_req), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post_rst_req%0d", i), 32'(dm_req), 32'd0);
    end
    chk("post_rst_empty", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
